fb_arbiter: RTL and testbench



---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_tag_pipe.sv | 25 ++
 rtl/fb_arbiter.sv | 147 ++++++++++++++
 tb/tb_fb_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame-buffer port ids, tag type and default widths
package fb_pkg;

   localparam int FB_ADDR_W = 12;
   localparam int FB_DATA_W = 16;

   localparam logic [1:0] FB_PORT_GPMC = 2'd0;
   localparam logic [1:0] FB_PORT_LED0 = 2'd1;
   localparam logic [1:0] FB_PORT_LED1 = 2'd2;

   localparam int FB_TAG_W = 3;

   typedef struct packed {
      logic       valid;
      logic [1:0] id;
   } fb_tag_t;

   function automatic logic [2:0] fb_port_onehot(input logic [1:0] id);
      fb_port_onehot = 3'b001 << id;
   endfunction

endpackage

// File: rtl/fb_tag_pipe.sv
// rtl/fb_tag_pipe.sv - read-tag shift register matching the RAM command-to-data latency
module fb_tag_pipe
   import fb_pkg::*;
#(
   parameter int DEPTH = 3
)(
   input  logic    clk_100,
   input  logic    reset_n,
   input  fb_tag_t tag_in,
   output fb_tag_t tag_out
);

   fb_tag_t [DEPTH-1:0] stage;

   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         stage <= '0;
      end else begin
         stage <= {stage[DEPTH-2:0], tag_in};
      end
   end

   assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port frame-buffer RAM arbiter: GPMC priority, LED round-robin, tagged read return
module fb_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int RD_LAT     = 2,
   parameter int MAX_STREAK = 4
)(
   input  logic                clk_100,
   input  logic                reset_n,
   input  logic                arb_en,
   input  logic [2:0]          req_valid,
   output logic [2:0]          req_ready,
   input  logic [2:0]          req_we,
   input  logic [3*ADDR_W-1:0] req_addr,
   input  logic [3*DATA_W-1:0] req_wdata,
   output logic [2:0]          rsp_valid,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int                  STREAK_W   = $clog2(MAX_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

   logic [STREAK_W-1:0] streak;
   logic [1:0]          rr_ptr;
   logic                led_valid;
   logic                gpmc_masked;
   logic                gnt_any;
   logic [1:0]          gnt_id;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   fb_tag_t             tag_in;
   fb_tag_t             tag_out;

   assign led_valid   = req_valid[FB_PORT_LED0] | req_valid[FB_PORT_LED1];
   assign gpmc_masked = (streak == STREAK_MAX) && led_valid;

   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = FB_PORT_GPMC;
      if (arb_en && reset_n) begin
         if (req_valid[FB_PORT_GPMC] && !gpmc_masked) begin
            gnt_any = 1'b1;
            gnt_id  = FB_PORT_GPMC;
         end else if (req_valid[FB_PORT_LED0] && req_valid[FB_PORT_LED1]) begin
            gnt_any = 1'b1;
            gnt_id  = rr_ptr;
         end else if (req_valid[FB_PORT_LED0]) begin
            gnt_any = 1'b1;
            gnt_id  = FB_PORT_LED0;
         end else if (req_valid[FB_PORT_LED1]) begin
            gnt_any = 1'b1;
            gnt_id  = FB_PORT_LED1;
         end
      end
   end

   assign req_ready = gnt_any ? fb_port_onehot(gnt_id) : 3'b000;

   always_comb begin
      sel_we    = req_we[0];
      sel_addr  = req_addr[0 +: ADDR_W];
      sel_wdata = req_wdata[0 +: DATA_W];
      case (gnt_id)
         FB_PORT_LED0: begin
            sel_we    = req_we[1];
            sel_addr  = req_addr[ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[DATA_W +: DATA_W];
         end
         FB_PORT_LED1: begin
            sel_we    = req_we[2];
            sel_addr  = req_addr[2*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[2*DATA_W +: DATA_W];
         end
         default: ;
      endcase
   end

   // streak only counts GPMC wins that actually held off a waiting LED port
   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         streak <= '0;
         rr_ptr <= FB_PORT_LED0;
      end else begin
         if (gnt_any && (gnt_id != FB_PORT_GPMC)) begin
            streak <= '0;
            rr_ptr <= (gnt_id == FB_PORT_LED0) ? FB_PORT_LED1 : FB_PORT_LED0;
         end else if (!led_valid) begin
            streak <= '0;
         end else if (gnt_any && (streak != STREAK_MAX)) begin
            streak <= streak + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= gnt_any;
         mem_we <= gnt_any & sel_we;
         if (gnt_any) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
         end
      end
   end

   always_comb begin
      tag_in       = '0;
      tag_in.valid = gnt_any && !sel_we;
      tag_in.id    = gnt_id;
   end

   // one extra stage covers the command register ahead of the RAM
   fb_tag_pipe #(
      .DEPTH (RD_LAT + 1)
   ) u_tag_pipe (
      .clk_100 (clk_100),
      .reset_n (reset_n),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= 3'b000;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= tag_out.valid ? fb_port_onehot(tag_out.id) : 3'b000;
         if (tag_out.valid) begin
            rsp_data <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - directed scoreboard bench for fb_arbiter
module tb_fb_arbiter;
   import fb_pkg::*;

   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 16;
   localparam int RD_LAT     = 2;
   localparam int MAX_STREAK = 4;

   typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } req_t;
   typedef struct { int port; logic [DATA_W-1:0] data; } rsp_t;
   typedef struct { int cyc; logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } cmd_t;
   typedef struct { int port; int cyc; } gnt_t;

   logic                clk_100 = 1'b0;
   logic                reset_n;
   logic                arb_en;
   logic [2:0]          req_valid = '0;
   logic [2:0]          req_ready;
   logic [2:0]          req_we = '0;
   logic [3*ADDR_W-1:0] req_addr = '0;
   logic [3*DATA_W-1:0] req_wdata = '0;
   logic [2:0]          rsp_valid;
   logic [DATA_W-1:0]   rsp_data;
   logic                mem_en;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   req_t q0[$], q1[$], q2[$];
   rsp_t exp_rsp[$];
   int   rd_cyc[$];
   cmd_t exp_cmd[$];
   gnt_t gnt_log[$];
   int   exp_gnt[$];

   logic              pl_en = 1'b0;
   logic [ADDR_W-1:0] pl_addr = '0;
   logic [DATA_W-1:0] pl_data = '0;
   logic [ADDR_W-1:0] pl_a [9] = '{12'h010, 12'h020, 12'h030, 12'h031, 12'h032, 12'h040, 12'h041, 12'h042, 12'h7FF};
   logic [DATA_W-1:0] pl_d [9] = '{16'h5A5A, 16'h2020, 16'h3000, 16'h3001, 16'h3002, 16'h4000, 16'h4001, 16'h4002, 16'h0000};

   fb_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .RD_LAT     (RD_LAT),
      .MAX_STREAK (MAX_STREAK)
   ) dut (
      .clk_100   (clk_100),
      .reset_n   (reset_n),
      .arb_en    (arb_en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk_100 = ~clk_100;

   always @(posedge clk_100) cyc <= cyc + 1;

   // write-first RAM with RD_LAT cycles from mem_en to mem_rdata
   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];

   always @(posedge clk_100) begin
      if (pl_en) ram[pl_addr] <= pl_data;
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            rd_pipe[0]    <= mem_wdata;
         end else begin
            rd_pipe[0] <= ram[mem_addr];
         end
      end
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   assign mem_rdata = rd_pipe[RD_LAT-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_req(input int p, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_t r;
      r.we = we; r.addr = a; r.wdata = d;
      case (p)
         0:       q0.push_back(r);
         1:       q1.push_back(r);
         default: q2.push_back(r);
      endcase
   endtask

   // requesters: hold the queue head on the bus until it transfers
   initial begin
      logic [2:0]          v, w;
      logic [3*ADDR_W-1:0] a;
      logic [3*DATA_W-1:0] d;
      forever begin
         @(negedge clk_100);
         v = '0; w = '0; a = '0; d = '0;
         if (q0.size() > 0) begin
            v[0] = 1'b1; w[0] = q0[0].we; a[0 +: ADDR_W] = q0[0].addr; d[0 +: DATA_W] = q0[0].wdata;
         end
         if (q1.size() > 0) begin
            v[1] = 1'b1; w[1] = q1[0].we; a[ADDR_W +: ADDR_W] = q1[0].addr; d[DATA_W +: DATA_W] = q1[0].wdata;
         end
         if (q2.size() > 0) begin
            v[2] = 1'b1; w[2] = q2[0].we; a[2*ADDR_W +: ADDR_W] = q2[0].addr; d[2*DATA_W +: DATA_W] = q2[0].wdata;
         end
         req_valid = v; req_we = w; req_addr = a; req_wdata = d;
      end
   end

   // grant sampler, just before each rising edge
   initial begin
      logic [2:0] x;
      int         p;
      req_t       r;
      forever begin
         @(negedge clk_100);
         #4;
         if (!arb_en) chk("ready_while_disabled", {29'd0, req_ready}, 32'd0);
         x = req_valid & req_ready;
         if (x != 3'b000) begin
            chk("grant_onehot", $countones(req_ready), 1);
            p = x[0] ? 0 : (x[1] ? 1 : 2);
            r.we = 1'b0; r.addr = '0; r.wdata = '0;
            case (p)
               0:       if (q0.size() > 0) r = q0.pop_front();
               1:       if (q1.size() > 0) r = q1.pop_front();
               default: if (q2.size() > 0) r = q2.pop_front();
            endcase
            gnt_log.push_back('{p, cyc});
            exp_cmd.push_back('{cyc + 1, r.we, r.addr, r.wdata});
            if (!r.we) rd_cyc.push_back(cyc);
         end
      end
   end

   // output monitor: RAM command and read responses
   initial begin
      cmd_t c;
      rsp_t e;
      int   g;
      forever begin
         @(negedge clk_100);
         #1;
         if (exp_cmd.size() > 0 && exp_cmd[0].cyc < cyc) begin
            chk("mem_en_missing", 0, 1);
            void'(exp_cmd.pop_front());
         end
         if (mem_en) begin
            if (exp_cmd.size() == 0) begin
               chk("mem_en_spurious", 1, 0);
            end else begin
               c = exp_cmd.pop_front();
               chk("mem_en_cycle", cyc, c.cyc);
               chk("mem_we", {31'd0, mem_we}, {31'd0, c.we});
               chk("mem_addr", {20'd0, mem_addr}, {20'd0, c.addr});
               if (c.we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, c.wdata});
            end
         end
         if (rsp_valid != 3'b000) begin
            if (exp_rsp.size() == 0 || rd_cyc.size() == 0) begin
               chk("rsp_spurious", {29'd0, rsp_valid}, 32'd0);
            end else begin
               e = exp_rsp.pop_front();
               g = rd_cyc.pop_front();
               chk("rsp_id", {29'd0, rsp_valid}, {29'd0, fb_port_onehot(e.port[1:0])});
               chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
               chk("rsp_latency", cyc - g, RD_LAT + 2);
            end
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (n < 200 && !(q0.size() == 0 && q1.size() == 0 && q2.size() == 0 &&
                          exp_rsp.size() == 0 && exp_cmd.size() == 0)) begin
         @(posedge clk_100);
         #1;
         n++;
      end
      chk("idle_timeout", {31'd0, n < 200}, 32'd1);
      repeat (6) @(posedge clk_100);
      #1;
   endtask

   task automatic begin_test();
      @(posedge clk_100);
      #1;
      gnt_log.delete();
      exp_gnt.delete();
   endtask

   task automatic check_grants(input string name);
      chk({name, "_count"}, gnt_log.size(), exp_gnt.size());
      for (int i = 0; i < exp_gnt.size() && i < gnt_log.size(); i++) begin
         chk($sformatf("%s_port%0d", name, i), gnt_log[i].port, exp_gnt[i]);
         if (i > 0) chk($sformatf("%s_gap%0d", name, i), gnt_log[i].cyc - gnt_log[i-1].cyc, 1);
      end
   endtask

   task automatic clear_sb();
      exp_rsp.delete();
      rd_cyc.delete();
      exp_cmd.delete();
   endtask

   task automatic apply_reset();
      @(posedge clk_100);
      #1;
      reset_n = 1'b0;
      clear_sb();
      repeat (2) @(posedge clk_100);
      @(negedge clk_100);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_req_ready"}, {29'd0, req_ready}, 32'd0);
      chk({name, "_rsp_valid"}, {29'd0, rsp_valid}, 32'd0);
      chk({name, "_rsp_data"}, {16'd0, rsp_data}, 32'd0);
      chk({name, "_mem_en"}, {31'd0, mem_en}, 32'd0);
      chk({name, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({name, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
      chk({name, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset_n = 1'b0;
      arb_en  = 1'b1;

      for (int i = 0; i < 9; i++) begin
         @(negedge clk_100);
         pl_en = 1'b1; pl_addr = pl_a[i]; pl_data = pl_d[i];
      end
      @(negedge clk_100);
      pl_en = 1'b0;

      // reset: a pending write must not be granted while reset_n is low
      @(posedge clk_100);
      #1;
      push_req(0, 1'b1, 12'h7FF, 16'h1234);
      @(negedge clk_100);
      #2;
      chk("reset_valid_presented", {29'd0, req_valid}, 32'd1);
      check_all_zero("reset");
      reset_n = 1'b1;
      wait_idle();

      // single read from LED port 1
      begin_test();
      exp_rsp.push_back('{1, 16'h5A5A});
      push_req(1, 1'b0, 12'h010, 16'h0000);
      wait_idle();
      exp_gnt = '{1};
      check_grants("single");

      // GPMC streams writes while LED port 2 waits
      begin_test();
      exp_rsp.push_back('{2, 16'h2020});
      push_req(2, 1'b0, 12'h020, 16'h0000);
      for (int i = 0; i < 8; i++) push_req(0, 1'b1, 12'h100 + 12'(i), 16'hABCD);
      wait_idle();
      exp_gnt = '{0, 0, 0, 0, 2, 0, 0, 0, 0};
      check_grants("starve");

      // LED round-robin from reset
      apply_reset();
      begin_test();
      for (int i = 0; i < 3; i++) begin
         exp_rsp.push_back('{1, 16'h3000 + 16'(i)});
         exp_rsp.push_back('{2, 16'h4000 + 16'(i)});
         push_req(1, 1'b0, 12'h030 + 12'(i), 16'h0000);
         push_req(2, 1'b0, 12'h040 + 12'(i), 16'h0000);
      end
      wait_idle();
      exp_gnt = '{1, 2, 1, 2, 1, 2};
      check_grants("rr");

      // write then read the same word, back to back
      begin_test();
      exp_rsp.push_back('{0, 16'hABCD});
      push_req(0, 1'b1, 12'hF00, 16'hABCD);
      push_req(0, 1'b0, 12'hF00, 16'h0000);
      wait_idle();
      exp_gnt = '{0, 0};
      check_grants("mixed");

      // drain: disable grants after two reads, third stays pending
      begin_test();
      exp_rsp.push_back('{1, 16'h3000});
      exp_rsp.push_back('{1, 16'h3001});
      push_req(1, 1'b0, 12'h030, 16'h0000);
      push_req(1, 1'b0, 12'h031, 16'h0000);
      push_req(1, 1'b0, 12'h032, 16'h0000);
      n = 0;
      while (n < 20 && gnt_log.size() < 2) begin
         @(posedge clk_100);
         #1;
         n++;
      end
      arb_en = 1'b0;
      chk("drain_grants_at_disable", gnt_log.size(), 2);
      repeat (10) @(posedge clk_100);
      #1;
      chk("drain_no_new_grant", gnt_log.size(), 2);
      chk("drain_pending", q1.size(), 1);
      chk("drain_rsp_done", exp_rsp.size(), 0);
      q1.delete();
      @(negedge clk_100);
      #1;
      arb_en = 1'b1;
      wait_idle();
      exp_gnt = '{1, 1};
      check_grants("drain");

      // reset two cycles after a read grant
      begin_test();
      push_req(1, 1'b0, 12'h031, 16'h0000);
      n = 0;
      while (n < 20 && gnt_log.size() < 1) begin
         @(posedge clk_100);
         #1;
         n++;
      end
      chk("midreset_granted", gnt_log.size(), 1);
      @(posedge clk_100);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      clear_sb();
      @(negedge clk_100);
      @(negedge clk_100);
      #1;
      reset_n = 1'b1;
      repeat (8) @(posedge clk_100);
      begin_test();
      exp_rsp.push_back('{1, 16'h3002});
      exp_rsp.push_back('{2, 16'h4002});
      push_req(1, 1'b0, 12'h032, 16'h0000);
      push_req(2, 1'b0, 12'h042, 16'h0000);
      wait_idle();
      exp_gnt = '{1, 2};
      check_grants("post_reset_rr");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
